// File: rtl/evabmof_udiv_seq.sv
// evabmof_udiv_seq: sequential restoring divider, 32-bit / 16-bit unsigned.
// One quotient bit is resolved per clock. Operands come in and results go out
// through valid/ready handshakes, and only one operation is in flight at a time.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high
//   CALC  | one restoring step per edge, cnt_q counts remaining steps
//   DONE  | result registered, out_valid high until out_ready
module evabmof_udiv_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      q_ovf
);

  localparam int NW = DIVIDEND_WIDTH;
  localparam int DW = DIVISOR_WIDTH;
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   q_q, q_d;
  logic [DW-1:0]   d_q, d_d;
  logic [DW:0]     r_q, r_d;
  logic [NW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  // Trial remainder is kept one bit wider than R. The sign bit of the
  // difference then acts as the borrow, so no separate comparator is needed.
  logic [DW+1:0]   t_ext;
  logic [DW+1:0]   diff;
  logic            ge;
  logic [DW:0]     r_next;
  logic [NW-1:0]   q_next;

  // State register and all datapath flops, synchronous active-high reset
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic; a zero divisor skips CALC entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded directly from state
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // One restoring step. R stays below D, so the restored value fits in DW+1 bits.
  always_comb begin
    t_ext  = {r_q, q_q[NW-1]};
    diff   = t_ext - {2'b00, d_q};
    ge     = ~diff[DW+1];
    r_next = ge ? diff[DW:0] : t_ext[DW:0];
    q_next = {q_q[NW-2:0], ge};
  end

  // Datapath register updates; result registers only change on entry to DONE
  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    d_d   = d_q;
    r_d   = r_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(NW);
          if (divisor == '0) begin
            quo_d = '1;
            rem_d = dividend[DW-1:0];
            dbz_d = 1'b1;
            ovf_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d = q_next;
          rem_d = r_next[DW-1:0];
          dbz_d = 1'b0;
          ovf_d = |q_next[NW-1:DW];
        end
      end
      default: ;
    endcase
  end

  // Registered results
  always_comb begin
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    q_ovf       = ovf_q;
  end

endmodule

// File: tb/tb_evabmof_udiv_seq.sv
// Directed bench for evabmof_udiv_seq. A reference model computes each
// expected result when the operands are sent and queues it. The queued
// result is popped and compared when out_valid rises.
module tb_evabmof_udiv_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        q_ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  evabmof_udiv_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .q_ovf(q_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a[15:0]; e.dbz = 1'b1; e.ovf = 1'b1; e.lat = 1;
    end else begin
      e.q   = a / {16'd0, b};
      e.r   = 16'(a % {16'd0, b});
      e.dbz = 1'b0;
      e.ovf = (e.q > 32'h0000_FFFF);
      e.lat = 32;
    end
    sb.push_back(e);
  endtask

  // Called just after a rising edge; presents operands, returns just after the accept edge
  task automatic send(input logic [31:0] a, input logic [15:0] b);
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge ap_clk); #1;
    in_valid = 1'b0; dividend = $urandom; divisor = 16'($urandom);
    push_exp(a, b);
  endtask

  // Waits for the result, compares it, holds backpressure for bp cycles, then drains
  task automatic recv(input int bp);
    exp_t        e;
    int          n;
    logic [31:0] q0;
    logic [15:0] r0;
    n = 0;
    do begin
      @(posedge ap_clk); #1; n++;
    end while (!out_valid && n < 100);
    chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("quotient", quotient, e.q);
      chk("remainder", {16'd0, remainder}, {16'd0, e.r});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      chk("q_ovf", {31'd0, q_ovf}, {31'd0, e.ovf});
    end
    q0 = quotient; r0 = remainder;
    for (int i = 0; i < bp; i++) begin
      @(posedge ap_clk); #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_quotient", quotient, q0);
      chk("bp_remainder", {16'd0, remainder}, {16'd0, r0});
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, q_ovf}, 32'd0);

    send(32'd1234567, 16'd1000);    recv(0);
    send(32'hFFFE_0001, 16'hFFFF);  recv(0);
    send(32'h0000_1234, 16'd0);     recv(0);
    send(32'h0001_0000, 16'd1);     recv(0);
    send(32'd0, 16'd5);             recv(0);
    send(32'd299, 16'd300);         recv(0);
    send(32'hDEAD_BEEF, 16'd1);     recv(0);
    for (int i = 0; i < 4; i++) begin
      send($urandom, 16'($urandom_range(1, 65535)));
      recv(0);
    end

    // Backpressure, then a new op offered on the drain edge
    send(32'd1000000, 16'd333);
    recv(5);
    send(32'd77777, 16'd12);
    begin
      exp_t  e;
      int    n;
      n = 0;
      do begin
        @(posedge ap_clk); #1; n++;
      end while (!out_valid && n < 100);
      chk("bp2_latency", n, 32);
      e = sb.pop_front();
      chk("bp2_quotient", quotient, e.q);
      repeat (5) begin
        @(posedge ap_clk); #1;
        chk("bp2_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp2_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1; in_valid = 1'b1; dividend = 32'd5000; divisor = 16'd7;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      chk("bp2_idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp2_idle_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      chk("bp2_accepted", {31'd0, in_ready}, 32'd0);
      push_exp(32'd5000, 16'd7);
      recv(0);
    end

    // Reset during the 10th iteration
    send(32'hCAFE_1234, 16'd99);
    repeat (9) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    void'(sb.pop_front());
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_quotient", quotient, 32'd0);
    chk("mid_rst_remainder", {16'd0, remainder}, 32'd0);
    chk("mid_rst_flags", {30'd0, div_by_zero, q_ovf}, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge ap_clk); #1;
        if (out_valid) seen++;
      end
      chk("no_pulse_after_rst", seen, 0);
    end
    send(32'd100, 16'd7);
    recv(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/evabmof_udiv_seq.md
Name: evabmof_udiv_seq

Overview:
- Sequential unsigned divider: the inverse of the 16x16 unsigned multiply used in the EVABMOF datapath.
- Given a 32-bit dividend and a 16-bit divisor, it produces a 32-bit quotient and a 16-bit remainder using one restoring-division step per clock.
- Used wherever a 32-bit product must be divided back to 16-bit units (block-match cost normalisation, flow averaging).
- Inputs and outputs use valid/ready handshakes; one operation is in flight at a time.

Parameters:
- DIVIDEND_WIDTH, 32, dividend and quotient width; also the iteration count W.
- DIVISOR_WIDTH, 16, divisor and remainder width.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DIVIDEND_WIDTH  unsigned numerator.
- divisor  in  DIVISOR_WIDTH  unsigned denominator.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  DIVIDEND_WIDTH  unsigned floor(dividend/divisor).
- remainder  out  DIVISOR_WIDTH  dividend mod divisor.
- div_by_zero  out  1  divisor was 0.
- q_ovf  out  1  quotient does not fit in DIVISOR_WIDTH bits.

Behaviour:
- Interface decision: one clock (ap_clk); reset ap_rst is synchronous and active-high.
- States: IDLE, CALC, DONE. The state register resets to IDLE.
- in_ready = (state==IDLE). It is decoded from state, so it is 1 from the first edge sampled with ap_rst high.
- out_valid = (state==DONE).
- Reset values: out_valid 0; quotient, remainder, div_by_zero, q_ovf all 0; iteration counter 0; working registers 0.
- IDLE: on an edge with in_valid && in_ready (the accept edge, k):
  - latch the dividend into Q and the divisor into D;
  - clear R (DIVISOR_WIDTH+1 bits);
  - load count = W.
  - If divisor==0, go to DONE instead, with quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], div_by_zero = 1, q_ovf = 1. out_valid is then high after edge k+1.
- CALC, one iteration per edge:
  - T = {R[DIVISOR_WIDTH-1:0], Q[msb]}; Q <<= 1.
  - If T >= {1'b0, D}: R = T - D and Q[0] = 1; otherwise R = T.
  - count decrements each iteration.
  - The edge on which count reaches 0 moves to DONE and registers the outputs:
    - quotient = Q;
    - remainder = R[DIVISOR_WIDTH-1:0];
    - div_by_zero = 0;
    - q_ovf = |Q[DIVIDEND_WIDTH-1:DIVISOR_WIDTH].
- Latency: iterations occur on edges k+1 .. k+W; out_valid is high after edge k+W (32 edges for the defaults).
- R never exceeds D-1 after restore, so DIVISOR_WIDTH+1 bits is sufficient with no overflow.
- DONE:
  - Outputs are held stable while out_valid && !out_ready, for any number of cycles.
  - An edge with out_ready=1 returns the block to IDLE.
  - in_ready is 0 in DONE, so no new accept happens on the drain edge.
  - Throughput is one op per W+2 cycles minimum.
- Output registers retain their last value in IDLE/CALC. Consumers must qualify them with out_valid.
- in_valid is ignored in CALC and DONE; operands are sampled only on the accept edge.
- Operand inputs may change freely after acceptance.
- Reset mid-operation (any state): the operation is abandoned; all registers return to reset values; the state is IDLE after that edge; no out_valid pulse is produced.
- Dividend 0 with a nonzero divisor gives quotient 0 and remainder 0 at normal latency.
- Divisor 1 gives quotient = dividend and remainder 0.
- Dividend < divisor gives quotient 0 and remainder = dividend.

Test Plan:
- dividend=1234567 (0x0012D687), divisor=1000 -> quotient=1234, remainder=567, div_by_zero=0, q_ovf=0; out_valid rises exactly 32 edges after the accept edge.
- dividend=0xFFFE0001 (0xFFFF*0xFFFF), divisor=0xFFFF -> quotient=0x0000FFFF, remainder=0, q_ovf=0, confirming exact inversion of the multiplier.
- dividend=0x00001234, divisor=0 -> quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, q_ovf=1; out_valid high 1 edge after accept.
- dividend=0x00010000, divisor=1 -> quotient=0x00010000, remainder=0, q_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs and out_valid are stable and in_ready=0; raise out_ready -> IDLE next edge, in_ready=1; a new op with in_valid held high is accepted on the following edge.
- Assert ap_rst for 1 cycle at the 10th CALC iteration -> out_valid stays 0, outputs are 0, in_ready=1; then dividend=100, divisor=7 -> quotient=14, remainder=2.
